// File: rtl/regfile_pkg.sv
// Shared types for the multi-port register file and its clear sequencer.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, then holds READY until the next reset.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  output logic              clr_we,
  output logic [AWIDTH-1:0] clr_addr,
  output logic              ready,
  output logic              init_done,
  output logic              wr_drop
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  state_e            state_q;
  logic [AWIDTH-1:0] clr_ptr_q;
  logic              init_done_q;
  logic              wr_drop_q;

  // Clear FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      init_done_q <= 1'b0;
      wr_drop_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + AWIDTH'(1);
          wr_drop_q <= wr_en;
          if (clr_ptr_q == LAST_ADDR) begin
            state_q     <= ST_READY;
            init_done_q <= 1'b1;
          end else begin
            state_q     <= ST_CLEAR;
            init_done_q <= 1'b0;
          end
        end
        ST_READY: begin
          wr_drop_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_CLEAR;
          clr_ptr_q   <= '0;
          init_done_q <= 1'b0;
          wr_drop_q   <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we    = (state_q == ST_CLEAR);
  assign clr_addr  = clr_ptr_q;
  assign ready     = (state_q == ST_READY);
  assign init_done = init_done_q;
  assign wr_drop   = wr_drop_q;

endmodule

// File: rtl/regfile_mp.sv
// Register file with one write port, NRD registered read ports, optional zero entry and
// optional write-to-read bypass; contents are cleared by a sequencer after reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DWIDTH   = 64,
  parameter int unsigned AWIDTH   = 5,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AWIDTH-1:0]     wr_addr,
  input  logic [DWIDTH-1:0]     wr_data,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*AWIDTH-1:0] rd_addr,
  output logic [NRD*DWIDTH-1:0] rd_data,
  output logic                  init_done,
  output logic                  wr_drop
);

  localparam int unsigned NADDR = 2 ** AWIDTH;

  // Addresses that map to real, writable storage; everything else reads as zero.
  function automatic logic [NADDR-1:0] build_addr_ok();
    logic [NADDR-1:0] m;
    m = '0;
    for (int i = 0; i < int'(NADDR); i++) begin
      m[i] = (i < int'(DEPTH));
    end
    if (ZERO_REG != 32'd0) begin
      m[0] = 1'b0;
    end
    return m;
  endfunction

  localparam logic [NADDR-1:0] ADDR_OK = build_addr_ok();

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic              clr_we_s;
  logic [AWIDTH-1:0] clr_addr_s;
  logic              ready_s;
  logic              wr_ok_s;
  logic              arr_we_s;
  logic [AWIDTH-1:0] arr_addr_s;
  logic [DWIDTH-1:0] arr_data_s;

  regfile_clear_seq #(
    .AWIDTH (AWIDTH),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .clr_we    (clr_we_s),
    .clr_addr  (clr_addr_s),
    .ready     (ready_s),
    .init_done (init_done),
    .wr_drop   (wr_drop)
  );

  assign wr_ok_s = ready_s & wr_en & ADDR_OK[wr_addr];

  // Single array write port shared between the clear sequencer and the user
  always_comb begin
    arr_we_s   = 1'b0;
    arr_addr_s = '0;
    arr_data_s = '0;
    if (clr_we_s) begin
      arr_we_s   = 1'b1;
      arr_addr_s = clr_addr_s;
      arr_data_s = '0;
    end else begin
      arr_we_s   = wr_ok_s;
      arr_addr_s = wr_addr;
      arr_data_s = wr_data;
    end
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (arr_we_s) begin
      mem_q[arr_addr_s] <= arr_data_s;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AWIDTH-1:0] addr_s;
    logic [DWIDTH-1:0] val_s;
    logic [DWIDTH-1:0] data_q;

    assign addr_s = rd_addr[i*AWIDTH +: AWIDTH];

    // Read value select: zero / bypassed write data / stored entry
    always_comb begin
      val_s = '0;
      if (!ready_s || !ADDR_OK[addr_s]) begin
        val_s = '0;
      end else if ((BYPASS != 32'd0) && wr_ok_s && (wr_addr == addr_s)) begin
        val_s = wr_data;
      end else begin
        val_s = mem_q[addr_s];
      end
    end

    // Registered read data, held while the port is idle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
      end else if (rd_en[i]) begin
        data_q <= val_s;
      end
    end

    assign rd_data[i*DWIDTH +: DWIDTH] = data_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two instances (bypass+zero-reg, read-first+no-zero-reg) share one stimulus.
module tb_regfile_mp;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [4:0]    wr_addr = 5'd0;
  logic [63:0]   wr_data = 64'd0;
  logic [1:0]    rd_en = 2'b00;
  logic [9:0]    rd_addr = 10'd0;
  logic [127:0]  rd_data_a, rd_data_b;
  logic          init_done_a, init_done_b, wr_drop_a, wr_drop_b;

  int            checks = 0;
  int            failures = 0;
  logic [63:0]   exp_q[$];

  always #5 clk = ~clk;

  regfile_mp #(.DWIDTH(64), .AWIDTH(5), .DEPTH(32), .NRD(2), .BYPASS(1), .ZERO_REG(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .init_done(init_done_a), .wr_drop(wr_drop_a));

  regfile_mp #(.DWIDTH(64), .AWIDTH(5), .DEPTH(32), .NRD(2), .BYPASS(0), .ZERO_REG(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .init_done(init_done_b), .wr_drop(wr_drop_b));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the expected read results in monitor order.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [63:0] ea0, input logic [63:0] ea1,
                       input logic [63:0] eb0, input logic [63:0] eb1);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = {a1, a0};
    if (re[0]) exp_q.push_back(ea0);
    if (re[1]) exp_q.push_back(ea1);
    if (re[0]) exp_q.push_back(eb0);
    if (re[1]) exp_q.push_back(eb1);
  endtask

  // Monitor: each port enabled at an edge presents new data just after that edge.
  initial begin
    logic [1:0]  en_s;
    logic [63:0] act;
    logic [63:0] exp;
    forever begin
      @(posedge clk);
      en_s = rd_en;
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          if (en_s[p]) begin
            act = (d == 0) ? rd_data_a[p*64 +: 64] : rd_data_b[p*64 +: 64];
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL rd dut%0d port%0d: got %0h with no expected value queued", d, p, act);
            end else begin
              exp = exp_q.pop_front();
              check($sformatf("rd dut%0d port%0d", d, p), {64'd0, act}, {64'd0, exp});
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rd_data_a", rd_data_a, 128'd0);
    check("reset rd_data_b", rd_data_b, 128'd0);
    check("reset init_done", {126'd0, init_done_a, init_done_b}, 128'd0);
    check("reset wr_drop", {126'd0, wr_drop_a, wr_drop_b}, 128'd0);
    rst_n = 1'b1;

    // Clear phase: read every address as it is cleared; write at cycle 3 must be dropped.
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("init_done low c%0d", k), {126'd0, init_done_a, init_done_b}, 128'd0);
      if (k >= 3 && k <= 5)
        check($sformatf("wr_drop c%0d", k), {126'd0, wr_drop_a, wr_drop_b},
              (k == 4) ? 128'd3 : 128'd0);
      drive(k == 3, 5'd9, 64'h55, 2'b11, k[4:0], k[4:0], 64'd0, 64'd0, 64'd0, 64'd0);
    end
    @(negedge clk);
    check("init_done after 32", {126'd0, init_done_a, init_done_b}, 128'd3);
    check("wr_drop idle", {126'd0, wr_drop_a, wr_drop_b}, 128'd0);

    drive(1'b1, 5'd5, 64'hDEAD_BEEF, 2'b11, 5'd9, 5'd9, 64'd0, 64'd0, 64'd0, 64'd0);
    @(negedge clk);
    drive(1'b1, 5'd7, 64'hAAAA, 2'b11, 5'd5, 5'd5,
          64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
    @(negedge clk);
    drive(1'b1, 5'd7, 64'h1234, 2'b11, 5'd7, 5'd5,
          64'h1234, 64'hDEAD_BEEF, 64'hAAAA, 64'hDEAD_BEEF);
    @(negedge clk);
    drive(1'b1, 5'd0, 64'hFFFF, 2'b11, 5'd7, 5'd0, 64'h1234, 64'd0, 64'h1234, 64'd0);
    @(negedge clk);
    drive(1'b1, 5'd0, 64'h1111, 2'b11, 5'd0, 5'd0, 64'd0, 64'd0, 64'hFFFF, 64'hFFFF);
    @(negedge clk);
    drive(1'b0, 5'd0, 64'd0, 2'b11, 5'd0, 5'd7, 64'd0, 64'h1234, 64'h1111, 64'h1234);
    @(negedge clk);
    drive(1'b0, 5'd0, 64'd0, 2'b01, 5'd5, 5'd0, 64'hDEAD_BEEF, 64'd0, 64'hDEAD_BEEF, 64'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 64'd0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    check("hold port1 a", {64'd0, rd_data_a[127:64]}, 128'h1234);
    check("hold port1 b", {64'd0, rd_data_b[127:64]}, 128'h1234);

    // Reset again, then interrupt the clear at cycle 10.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset rd_data_a", rd_data_a, 128'd0);
    check("async reset rd_data_b", rd_data_b, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("init_done mid-clear", {126'd0, init_done_a, init_done_b}, 128'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!init_done_a && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("restart clear cycles", 128'(n), 128'd32);
    check("restart init_done_b", {127'd0, init_done_b}, 128'd1);

    @(negedge clk);
    drive(1'b0, 5'd0, 64'd0, 2'b11, 5'd5, 5'd7, 64'd0, 64'd0, 64'd0, 64'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 64'd0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    check("scoreboard drained", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
